ps2_keycode_rx: RTL and testbench

- PS/2 keyboard receiver and scancode translator.
- Deserialises device-to-host PS/2 frames and tracks make/break and extended prefixes.
- Translates the game's keys into the 8-bit HID-style keycode consumed by the jump/motion logic and the jump state machine.
- Sits between the PS/2 connector pins and every block that takes `keycode[7:0]`.
- Holds the code of the most recently pressed mapped key until that key is released.

---
 rtl/ps2_keycode_rx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes device-to-host bytes,
// and translates make/break scancodes of the game keys into an 8-bit usage code.
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_Clk,
    input  logic       PS2_Data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             keycode_q, keycode_d;
    logic                   key_event_q, key_event_d;

    logic       clk_s;
    logic       data_s;
    logic       fall;
    logic       timeout;
    logic       abort;
    logic [7:0] usage;

    function automatic logic [7:0] usage_of(input logic ext, input logic [7:0] sc);
        case ({ext, sc})
            9'h01C:  return 8'd4;
            9'h023:  return 8'd7;
            9'h016:  return 8'd30;
            9'h029:  return 8'd44;
            9'h05A:  return 8'd40;
            9'h076:  return 8'd41;
            9'h174:  return 8'd79;
            9'h16B:  return 8'd80;
            default: return 8'd0;
        endcase
    endfunction

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;
    // A falling edge in the timeout cycle takes priority, so the frame keeps going.
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], PS2_Clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], PS2_Data};
        clk_prev_d   = clk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        keycode_d    = keycode_q;
        abort        = 1'b0;
        usage        = usage_of(ext_q, rx_byte_q);

        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, parity_q})) begin
                        rx_byte_d    = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        abort       = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            abort       = 1'b1;
            to_cnt_d    = '0;
        end

        if (byte_valid_q) begin
            case (rx_byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                default: begin
                    if (usage != 8'd0) begin
                        if (!brk_q) begin
                            keycode_d = usage;
                        end else if (keycode_q == usage) begin
                            keycode_d = 8'd0;
                        end
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end

        // A corrupted frame may have been part of a prefixed sequence; drop any pending prefix.
        if (abort) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        key_event_d = (keycode_d != keycode_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            rx_byte_q    <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            keycode_q    <= 8'd0;
            key_event_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            keycode_q    <= keycode_d;
            key_event_q  <= key_event_d;
        end
    end

    assign keycode    = keycode_q;
    assign key_event  = key_event_q;
    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of PS/2 frames with expected keycode/event results,
// a scoreboard of expected byte/error pulses, and hand-written timeout and reset sequences.
module tb_ps2_keycode_rx;

    localparam int SYNC = 2;
    localparam int T    = 1000;
    localparam int H    = 10;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2_Clk = 1'b1;
    logic       PS2_Data = 1'b1;
    logic [7:0] keycode;
    logic       key_event;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_keycode_rx #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(T),
        .TO_W          (16)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_Clk   (PS2_Clk),
        .PS2_Data  (PS2_Data),
        .keycode   (keycode),
        .key_event (key_event),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        logic [7:0] exp_key;
        int         exp_ev;
    } vec_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ev_cnt = 0;
    int   pulse_cnt = 0;
    int   last_fall_cyc = 0;
    bit   bv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard side: every byte_valid/frame_err pulse must match the next expected frame outcome.
    always @(negedge Clk) begin
        if (key_event) begin
            ev_cnt++;
            check("ev_latency", 32'(bv_prev), 32'd1);
        end
        if (key_event || byte_valid || frame_err) pulse_cnt++;
        if (byte_valid || frame_err) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {byte_valid, frame_err}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_frame_err", 32'(frame_err), 32'(e.err));
                check("sb_byte_valid", 32'(byte_valid), 32'(!e.err));
                if (!e.err) check("sb_rx_byte", 32'(rx_byte), 32'(e.data));
            end
        end
        bv_prev = byte_valid;
    end

    task automatic ps2_bit(input logic b);
        PS2_Data = b;
        repeat (H) @(negedge Clk);
        PS2_Clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(negedge Clk);
        PS2_Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
        logic par;
        sb_t  e;
        par = ~(^d) ^ bad_par;
        e.err  = bad_par || !stop;
        e.data = d;
        sb.push_back(e);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stop);
        PS2_Data = 1'b1;
        repeat (3 * H) @(negedge Clk);
    endtask

    task automatic add(input logic [7:0] d, input bit bp, input bit st, input logic [7:0] k,
                       input int ev);
        vec_t v;
        v.data = d; v.bad_par = bp; v.stop = st; v.exp_key = k; v.exp_ev = ev;
        vecs.push_back(v);
    endtask

    initial begin
        int ev0;
        int waited;
        bit found;

        add(8'h23, 0, 1, 8'd7, 1);
        add(8'hF0, 0, 1, 8'd7, 0);
        add(8'h23, 0, 1, 8'd0, 1);
        add(8'h1C, 0, 1, 8'd4, 1);
        add(8'hF0, 0, 1, 8'd4, 0);
        add(8'h23, 0, 1, 8'd4, 0);
        add(8'h1C, 0, 1, 8'd4, 0);
        add(8'hE0, 0, 1, 8'd4, 0);
        add(8'h74, 0, 1, 8'd79, 1);
        add(8'h16, 0, 1, 8'd30, 1);
        add(8'h74, 0, 1, 8'd30, 0);
        add(8'h16, 1, 1, 8'd30, 0);
        add(8'h16, 0, 0, 8'd30, 0);
        add(8'hE0, 0, 1, 8'd30, 0);
        add(8'h1C, 1, 1, 8'd30, 0);
        add(8'h74, 0, 1, 8'd30, 0);
        add(8'h29, 0, 1, 8'd44, 1);
        add(8'h5A, 0, 1, 8'd40, 1);
        add(8'h76, 0, 1, 8'd41, 1);
        add(8'hE0, 0, 1, 8'd41, 0);
        add(8'h6B, 0, 1, 8'd80, 1);
        add(8'hF0, 0, 1, 8'd80, 0);
        add(8'h6B, 0, 1, 8'd80, 0);
        add(8'hE0, 0, 1, 8'd80, 0);
        add(8'hF0, 0, 1, 8'd80, 0);
        add(8'h6B, 0, 1, 8'd0, 1);

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_keycode", 32'(keycode), 32'd0);
        check("rst_key_event", 32'(key_event), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        repeat (1000) @(negedge Clk);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            ev0 = ev_cnt;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);
            check($sformatf("vec%0d_keycode", i), 32'(keycode), 32'(vecs[i].exp_key));
            check($sformatf("vec%0d_events", i), 32'(ev_cnt - ev0), 32'(vecs[i].exp_ev));
        end

        // Partial frame: start bit plus four data bits, then the PS/2 clock stops.
        begin
            sb_t e;
            e.err = 1'b1; e.data = 8'h00;
            sb.push_back(e);
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        PS2_Data = 1'b1;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 3 * T) begin
            @(negedge Clk);
            if (frame_err) found = 1'b1;
            waited++;
        end
        check("to_seen", 32'(found), 32'd1);
        check("to_delay", 32'(cyc - last_fall_cyc), 32'(T + SYNC + 1));
        repeat (3 * H) @(negedge Clk);
        ev0 = ev_cnt;
        send_frame(8'h1C, 0, 1);
        check("after_to_keycode", 32'(keycode), 32'd4);
        check("after_to_events", 32'(ev_cnt - ev0), 32'd1);

        // Reset pulse in the middle of a frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        PS2_Data = 1'b1;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_keycode", 32'(keycode), 32'd0);
        check("mid_rst_key_event", 32'(key_event), 32'd0);
        check("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_rx_byte", 32'(rx_byte), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        pulse_cnt = 0;
        repeat (T + 100) @(negedge Clk);
        check("mid_rst_no_pulse", 32'(pulse_cnt), 32'd0);
        ev0 = ev_cnt;
        send_frame(8'h5A, 0, 1);
        check("after_rst_keycode", 32'(keycode), 32'd40);
        check("after_rst_events", 32'(ev_cnt - ev0), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
